// File: rtl/fc_pkg.sv
// fc_pkg: shared state encoding, datapath defaults and weight-bank bases for the FC MAC stage
package fc_pkg;
    localparam int FC_DATA_W  = 8;
    localparam int FC_ACC_W   = 24;
    localparam int FC_LEN     = 192;
    localparam int FC_W0_BASE = 0;
    localparam int FC_W1_BASE = 192;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} fc_state_t;
endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane with clear/enable; saturating when FC_MAC_SAT_EN is defined
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int ACC_W  = FC_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] feat,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  acc
`ifdef FC_MAC_SAT_EN
    ,
    output logic                     clip
`endif
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    nxt;
    assign prod = feat * w;
`ifdef FC_MAC_SAT_EN
    localparam logic signed [ACC_W:0] MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN = {2'b11, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0] sum;
    logic hi, lo;
    assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    assign hi   = sum > MAX;
    assign lo   = sum < MIN;
    assign clip = en && (hi || lo);
    assign nxt  = hi ? MAX[ACC_W-1:0] : lo ? MIN[ACC_W-1:0] : sum[ACC_W-1:0];
`else
    assign nxt = acc + ACC_W'(prod);
`endif
    // accumulator: clear on start, add product on each accepted beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= nxt;
    end
endmodule

// File: rtl/fc_mac_accum.sv
// fc_mac_accum: dual-lane FC dot-product accumulator with valid/ready result handshake (option: FC_MAC_SAT_EN)
module fc_mac_accum
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int ACC_W  = FC_ACC_W,
    parameter int LEN    = FC_LEN,
    parameter int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] feat,
    input  logic signed [DATA_W-1:0] w0,
    input  logic signed [DATA_W-1:0] w1,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  acc0,
    output logic signed [ACC_W-1:0]  acc1,
    output logic                     busy,
    output logic [CNT_W-1:0]         beat_cnt
`ifdef FC_MAC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);
    fc_state_t state, state_nxt;
    logic clr, en, last;
    assign clr  = (state == IDLE) && start;
    assign en   = (state == ACCUM) && in_valid;
    assign last = beat_cnt == CNT_W'(LEN - 1);
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // next state: start only counts in IDLE, final beat enters HOLD, handshake returns to IDLE
    always_comb begin
        state_nxt = (state == IDLE)  ? (start ? ACCUM : IDLE) :
                    (state == ACCUM) ? ((en && last) ? HOLD : ACCUM) :
                                       (out_ready ? IDLE : HOLD);
    end
    // outputs decoded from the state register only
    always_comb begin
        in_ready  = state == ACCUM;
        out_valid = state == HOLD;
        busy      = state != IDLE;
    end
    // beat counter wraps to zero on the final beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            beat_cnt <= '0;
        else if (clr)
            beat_cnt <= '0;
        else if (en)
            beat_cnt <= last ? '0 : beat_cnt + 1'b1;
    end
`ifdef FC_MAC_SAT_EN
    logic clip0, clip1;
    // sticky saturation flag, cleared by start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sat_flag <= 1'b0;
        else if (clr)
            sat_flag <= 1'b0;
        else if (clip0 || clip1)
            sat_flag <= 1'b1;
    end
`endif
    fc_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane0 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .feat(feat), .w(w0), .acc(acc0)
`ifdef FC_MAC_SAT_EN
        , .clip(clip0)
`endif
    );
    fc_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane1 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .feat(feat), .w(w1), .acc(acc1)
`ifdef FC_MAC_SAT_EN
        , .clip(clip1)
`endif
    );
endmodule
